// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// Module : coreUtils (package)
// Brief  : Shared FSM state encoding and counter widths for hazard_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package coreUtils;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_MEM_WAIT = 2'd2,
    HZ_ERR      = 2'd3
  } hz_state_t;

  // Wide enough for the largest legal MEM_TIMEOUT (255)
  localparam int HZ_CNT_W  = 8;
  localparam int HZ_PERF_W = 32;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_cmp.sv
// ============================================================================
// Module : hazard_cmp
// Brief  : Combinational load-use hazard detector (EX load vs. ID sources).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_cmp (
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_isLoad,
  input  logic       i_ex_Wreg,
  output logic       o_hazard
);

  logic w_ld_writes;
  logic w_hit_rs1;
  logic w_hit_rs2;

  // x0 is hard-wired zero, so a load targeting it can never be a producer
  assign w_ld_writes = i_ex_isLoad & i_ex_Wreg & (i_ex_rd != 5'd0);
  assign w_hit_rs1   = i_id_use_rs1 & (i_id_rs1 == i_ex_rd);
  assign w_hit_rs2   = i_id_use_rs2 & (i_id_rs2 == i_ex_rd);
  assign o_hazard    = w_ld_writes & (w_hit_rs1 | w_hit_rs2);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module : hazard_ctrl
// Brief  : Pipeline hazard FSM: load-use stall, memory-wait freeze with
//          timeout, branch flush. Optional perf counters: HAZARD_PERF_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
  import coreUtils::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_isLoad,
  input  logic       ex_Wreg,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       stall_if,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic       flush_id,
  output logic       flush_ex,
  output logic       freeze_all,
  output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [HZ_PERF_W-1:0] lu_stall_cnt,
  output logic [HZ_PERF_W-1:0] mem_stall_cnt,
  output logic [HZ_PERF_W-1:0] flush_cnt
`endif
);

  localparam logic [HZ_CNT_W-1:0] c_TIMEOUT = HZ_CNT_W'(MEM_TIMEOUT);

  hz_state_t             r_state;
  hz_state_t             w_state_nxt;
  logic [HZ_CNT_W-1:0]   r_wait_cnt;
  logic [HZ_CNT_W-1:0]   w_cnt_nxt;
  logic                  r_br_pend;
  logic                  w_pend_nxt;
  logic                  w_hazard;
  logic                  w_branch;
  logic                  w_unfrozen;
  logic                  w_lu_ok;
  logic                  w_stall;
  logic                  w_flush;
  logic                  w_freeze;
  logic                  w_err;

  hazard_cmp u_cmp (
    .i_id_rs1     (id_rs1),
    .i_id_rs2     (id_rs2),
    .i_id_use_rs1 (id_use_rs1),
    .i_id_use_rs2 (id_use_rs2),
    .i_ex_rd      (ex_rd),
    .i_ex_isLoad  (ex_isLoad),
    .i_ex_Wreg    (ex_Wreg),
    .o_hazard     (w_hazard)
  );

  // A branch seen while frozen is remembered and acted on once unfrozen
  assign w_branch = ex_branch_taken | r_br_pend;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_wait_cnt;
    w_pend_nxt  = r_br_pend;
    w_unfrozen  = 1'b0;
    w_lu_ok     = 1'b0;
    w_stall     = 1'b0;
    w_flush     = 1'b0;
    w_freeze    = 1'b0;
    w_err       = 1'b0;

    case (r_state)
      HZ_ERR: begin
        w_freeze = 1'b1;
        w_err    = 1'b1;
      end
      HZ_MEM_WAIT: begin
        if (!mem_ready) begin
          w_freeze   = 1'b1;
          w_pend_nxt = r_br_pend | ex_branch_taken;
          w_cnt_nxt  = r_wait_cnt + 1'b1;
          if (w_cnt_nxt == c_TIMEOUT) begin
            w_state_nxt = HZ_ERR;
          end
        end else begin
          w_unfrozen = 1'b1;
          w_lu_ok    = 1'b1;
        end
      end
      default: begin
        if (mem_req && !mem_ready) begin
          w_freeze    = 1'b1;
          w_pend_nxt  = r_br_pend | ex_branch_taken;
          w_cnt_nxt   = '0;
          w_state_nxt = HZ_MEM_WAIT;
        end else begin
          w_unfrozen = 1'b1;
          // The cycle after a stall must not re-stall on the same pair
          w_lu_ok    = (r_state == HZ_RUN);
        end
      end
    endcase

    if (w_unfrozen) begin
      w_state_nxt = HZ_RUN;
      if (w_branch) begin
        w_flush    = 1'b1;
        w_pend_nxt = 1'b0;
      end else if (w_lu_ok && w_hazard) begin
        w_stall     = 1'b1;
        w_state_nxt = HZ_LU_STALL;
      end
    end
  end

  assign stall_if   = w_stall  & ~rst;
  assign stall_id   = w_stall  & ~rst;
  assign bubble_ex  = w_stall  & ~rst;
  assign flush_id   = w_flush  & ~rst;
  assign flush_ex   = w_flush  & ~rst;
  assign freeze_all = w_freeze & ~rst;
  assign mem_err    = w_err    & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= HZ_RUN;
      r_wait_cnt <= '0;
      r_br_pend  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_cnt_nxt;
      r_br_pend  <= w_pend_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_stall_cnt  <= '0;
      mem_stall_cnt <= '0;
      flush_cnt     <= '0;
    end else begin
      if (w_stall)  lu_stall_cnt  <= lu_stall_cnt  + 1'b1;
      if (w_freeze) mem_stall_cnt <= mem_stall_cnt + 1'b1;
      if (w_flush)  flush_cnt     <= flush_cnt     + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: maximum number of consecutive MEM_WAIT cycles before an error is raised; range 1..255.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have ports id_rs1 and id_rs2, input, 5 each: source registers of the instruction in ID.
REQ-005 SHALL have ports id_use_rs1 and id_use_rs2, input, 1 each: the ID instruction reads that source.
REQ-006 SHALL have ports ex_rd (input, 5), ex_isLoad (input, 1) and ex_Wreg (input, 1): destination register and control flags of the instruction in EX.
REQ-007 SHALL have port ex_branch_taken, input, 1: the branch or jump in EX redirects the PC this cycle.
REQ-008 SHALL have ports mem_req (input, 1), asserted when the MEM stage has Rmem or Wmem set, and mem_ready (input, 1), the data-memory acknowledge.
REQ-009 SHALL have outputs stall_if, stall_id, bubble_ex, flush_id, flush_ex and freeze_all, each 1 bit: pipeline-register enables and clears.
REQ-010 SHALL have output mem_err, 1: sticky memory-timeout flag.

Function
REQ-011 SHALL implement an FSM with states RUN, LU_STALL, MEM_WAIT and ERR; the state SHALL be RUN after reset.
REQ-012 SHALL detect a load-use hazard when all of the following hold:
- ex_isLoad & ex_Wreg & (ex_rd != 0);
- the hazard matches rs1 (id_use_rs1 & id_rs1 == ex_rd) or rs2 (id_use_rs2 & id_rs2 == ex_rd).
REQ-013 In RUN with a load-use hazard, no mem wait and no taken branch, SHALL assert stall_if, stall_id and bubble_ex for exactly one cycle, then return to RUN.
REQ-014 In RUN with mem_req=1 and mem_ready=0, SHALL assert freeze_all the same cycle, zero the wait counter and enter MEM_WAIT.
REQ-015 In MEM_WAIT:
- SHALL hold freeze_all=1 and increment the wait counter each cycle;
- on mem_ready=1, SHALL deassert freeze_all that cycle and return to RUN;
- when the counter reaches MEM_TIMEOUT, SHALL enter ERR.
REQ-016 ex_branch_taken with no freeze SHALL assert flush_id and flush_ex for one cycle.
REQ-017 A taken branch SHALL suppress any load-use stall in the same cycle.
REQ-018 Priority SHALL be: ERR > MEM_WAIT/mem stall > branch flush > load-use stall.
REQ-019 While freeze_all=1:
- flush_id and flush_ex SHALL stay 0;
- the branch SHALL be acted on in the first unfrozen cycle.
REQ-020 ERR SHALL hold freeze_all=1 and mem_err=1 until rst.
REQ-021 The stall and flush outputs SHALL be combinational from state and inputs; state and counters SHALL be registered.
REQ-022 Source register x0 SHALL never produce a hazard.

Reset
REQ-023 While rst=1:
- all outputs SHALL be 0 and mem_err SHALL be 0;
- the state SHALL be RUN and the counters SHALL be 0.
REQ-024 Reset asserted in MEM_WAIT or ERR SHALL return the block to RUN on the next edge.

Configuration
REQ-025 SHALL honour macro HAZARD_PERF_CNT_EN:
- when defined, SHALL add 32-bit outputs lu_stall_cnt, mem_stall_cnt and flush_cnt, each incrementing once per affected cycle and wrapping at 2^32, reset to 0;
- when undefined, these ports and counters SHALL be absent.

Structure
REQ-026 The FSM state enum hz_state_t and the counter width constant SHALL go in coreUtils.
REQ-027 The hazard comparator SHALL be a sub-module, hazard_cmp, purely combinational; the FSM SHALL stay in hazard_ctrl.

Verification
REQ-028 Load-use, rs1 side:
- stimulus: ex_isLoad=1, ex_Wreg=1, ex_rd=5, id_rs1=5, id_use_rs1=1;
- response: stall_if, stall_id and bubble_ex high for 1 cycle, then 0.
REQ-029 Load-use to x0:
- stimulus: ex_rd=0 with id_rs1=0;
- response: no stall.
REQ-030 Memory wait:
- stimulus: mem_req=1 with mem_ready low for 3 cycles;
- response: freeze_all high for 3 cycles, low in the cycle mem_ready=1.
REQ-031 Timeout:
- stimulus: MEM_TIMEOUT=4, mem_ready held 0;
- response: mem_err=1 after 4 wait cycles and held; rst clears it.
REQ-032 Branch versus load-use:
- stimulus: ex_branch_taken=1 together with a load-use match;
- response: flush_id=flush_ex=1, stall_if=0.
REQ-033 Branch during freeze:
- stimulus: ex_branch_taken=1 during MEM_WAIT;
- response: flush_id and flush_ex asserted in the first cycle after mem_ready.
